uart_tx_ctrl: RTL

Sequencer for the UART transmit path. It pops bytes from the TX FIFO when the FIFO is non-empty and transmission is enabled, then serialises each byte onto the line. Each frame is a start bit, 8 data bits LSB-first, an optional even-parity bit, and 1 or 2 stop bits. It sits between the TX FIFO read side and the `tx` pin, and owns baud timing and busy/done status for the UART top.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_ctrl_if.sv | 23 ++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit sequencer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int unsigned DEFAULT_CLK_DIV = 868;
    localparam int unsigned DATA_BITS       = 8;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// FIFO read side and serial-line status bundle between the TX sequencer and its surroundings.
interface uart_tx_ctrl_if;
    import uart_pkg::*;

    logic                 tx_en;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_rd_en;
    logic                 tx;
    logic                 busy;
    logic                 done;

    modport master (
        output tx_en, fifo_empty, fifo_rdata,
        input  fifo_rd_en, tx, busy, done
    );

    modport slave (
        input  tx_en, fifo_empty, fifo_rdata,
        output fifo_rd_en, tx, busy, done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_end marks the last cycle of every CLK_DIV-cycle bit while run is high.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Holding the reload value while idle lets the first bit start with a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!run || cnt_q == '0) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign bit_end = run && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops a byte from the TX FIFO and frames it as start, 8 data bits
// LSB-first, optional even parity and 1 or 2 stop bits on a registered tx line.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int unsigned PARITY_EN = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_ctrl_if.slave  bus
);

    localparam int unsigned STOP_CYCLES = STOP_BITS * CLK_DIV;
    localparam int          STOP_W      = $clog2(STOP_CYCLES + 1);
    localparam logic [STOP_W-1:0] STOP_LOAD = STOP_W'(STOP_CYCLES - 1);
    localparam int          IDX_W       = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(DATA_BITS - 1);

    tx_state_t            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [STOP_W-1:0]    stop_cnt_q;
    logic                 tx_q;
    logic                 done_q;

    logic run;
    logic bit_end;
    logic pop;

    assign run = (state_q == START) || (state_q == DATA) ||
                 (state_q == PARITY) || (state_q == STOP);

    // The pop must land in the IDLE cycle itself so the FIFO data is ready during LOAD.
    assign pop = !rst && (state_q == IDLE) && bus.tx_en && !bus.fifo_empty;

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .bit_end (bit_end)
    );

    // tx is loaded on each transition with the level of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_idx_q  <= '0;
            stop_cnt_q <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    shift_q   <= bus.fifo_rdata;
                    parity_q  <= even_parity(bus.fifo_rdata);
                    bit_idx_q <= '0;
                    tx_q      <= 1'b0;
                    state_q   <= START;
                end
                START: begin
                    if (bit_end) begin
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                tx_q    <= parity_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q       <= 1'b1;
                                stop_cnt_q <= STOP_LOAD;
                                state_q    <= STOP;
                            end
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx_q       <= 1'b1;
                        stop_cnt_q <= STOP_LOAD;
                        state_q    <= STOP;
                    end
                end
                STOP: begin
                    stop_cnt_q <= stop_cnt_q - 1'b1;
                    if (stop_cnt_q == STOP_W'(1)) begin
                        done_q <= 1'b1;
                    end
                    if (stop_cnt_q == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_rd_en = pop;
    assign bus.tx         = tx_q;
    assign bus.busy       = pop || (state_q != IDLE);
    assign bus.done       = done_q;

endmodule
